// File: rtl/pdh_adc_axis.sv
`default_nettype none
// ============================================================================
//  Module   : pdh_adc_axis
//  Purpose  : Dual-channel ADC front end for the PDH lock. Registers both raw
//             ADC channels, sign-extends them to 16 bits and optionally
//             negates them with saturation. It then box-car averages 2^N
//             samples per channel and emits one AXI-Stream beat per window.
//             The stream has no tready; downstream always accepts.
//  Ports    : clk              - ADC-domain clock (only clock)
//             rst_n            - asynchronous active-low reset
//             adc_dat_a_i/b_i  - raw two's-complement samples, valid every clk
//             enable_i         - run (1) / flush and hold (0)
//             avg_log2_i       - averaging exponent N, latched per window
//             M_AXIS_tdata_o   - {B[15:0], A[15:0]} window averages
//             M_AXIS_tvalid_o  - one-cycle pulse per averaged beat
//             clip_o           - window held a full-scale sample (with tvalid)
//             beat_cnt_o       - free-running count of emitted beats
//  Revision : 1.0 - initial release
// ============================================================================
module pdh_adc_axis #(
  parameter int ADC_WIDTH        = 14,
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int MAX_LOG2_AVG     = 4,
  parameter int INVERT           = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [ADC_WIDTH-1:0]        adc_dat_a_i,
  input  logic [ADC_WIDTH-1:0]        adc_dat_b_i,
  input  logic                        enable_i,
  input  logic [2:0]                  avg_log2_i,
  output logic [AXIS_TDATA_WIDTH-1:0] M_AXIS_tdata_o,
  output logic                        M_AXIS_tvalid_o,
  output logic                        clip_o,
  output logic [31:0]                 beat_cnt_o
);

  localparam int ACC_W  = 16 + MAX_LOG2_AVG;
  localparam int CNT_W  = (MAX_LOG2_AVG > 0) ? MAX_LOG2_AVG : 1;
  localparam int CNT_W1 = CNT_W + 1;

  // avg_log2_i is only 3 bits wide, so the usable exponent never exceeds 7.
  localparam logic [3:0] N_MAX = (MAX_LOG2_AVG >= 7) ? 4'd7 : 4'(MAX_LOG2_AVG);

  localparam logic [ADC_WIDTH-1:0] RAW_MAX = {1'b0, {(ADC_WIDTH-1){1'b1}}};
  localparam logic [ADC_WIDTH-1:0] RAW_MIN = {1'b1, {(ADC_WIDTH-1){1'b0}}};
  localparam logic signed [15:0]   SMP_MAX = 16'((1 << (ADC_WIDTH-1)) - 1);
  localparam logic signed [15:0]   SMP_MIN = ~SMP_MAX;

  // Sign-extend to 16 bits; when inverting, the most negative code maps to
  // the most positive one instead of wrapping back onto itself.
  function automatic logic signed [15:0] condition_sample(input logic [ADC_WIDTH-1:0] raw);
    logic signed [15:0] ext;
    logic signed [15:0] res;
    ext = 16'(signed'(raw));
    res = ext;
    if (INVERT != 0) begin
      if (ext == SMP_MIN) res = SMP_MAX;
      else                res = -ext;
    end
    return res;
  endfunction

  // --------------------------------------------------------------------------
  // Stage 1: raw input registers. enable_i and avg_log2_i travel with the
  // sample, so a window's run state and exponent belong to its samples.
  // --------------------------------------------------------------------------
  logic [ADC_WIDTH-1:0] r_s1_a;
  logic [ADC_WIDTH-1:0] r_s1_b;
  logic                 r_s1_valid;
  logic [2:0]           r_s1_avg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_valid <= 1'b0;
      r_s1_avg   <= '0;
    end else begin
      r_s1_a     <= adc_dat_a_i;
      r_s1_b     <= adc_dat_b_i;
      r_s1_valid <= enable_i;
      r_s1_avg   <= avg_log2_i;
    end
  end

  // --------------------------------------------------------------------------
  // Stage 2: conditioned samples, raw full-scale detect, clamped exponent
  // --------------------------------------------------------------------------
  logic signed [15:0] r_s2_a;
  logic signed [15:0] r_s2_b;
  logic               r_s2_clip;
  logic               r_s2_valid;
  logic [2:0]         r_s2_avg;
  logic [2:0]         w_avg_clamped;
  logic               w_raw_clip;

  assign w_avg_clamped = ({1'b0, r_s1_avg} > N_MAX) ? N_MAX[2:0] : r_s1_avg;
  assign w_raw_clip    = (r_s1_a == RAW_MAX) || (r_s1_a == RAW_MIN) ||
                         (r_s1_b == RAW_MAX) || (r_s1_b == RAW_MIN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_a     <= '0;
      r_s2_b     <= '0;
      r_s2_clip  <= 1'b0;
      r_s2_valid <= 1'b0;
      r_s2_avg   <= '0;
    end else begin
      r_s2_a     <= condition_sample(r_s1_a);
      r_s2_b     <= condition_sample(r_s1_b);
      r_s2_clip  <= w_raw_clip;
      r_s2_valid <= r_s1_valid;
      r_s2_avg   <= w_avg_clamped;
    end
  end

  // --------------------------------------------------------------------------
  // Stage 3: window accumulation and beat output
  // --------------------------------------------------------------------------
  logic [CNT_W-1:0]         r_cnt;
  logic [2:0]               r_n;
  logic signed [ACC_W-1:0]  r_acc_a;
  logic signed [ACC_W-1:0]  r_acc_b;
  logic                     r_clip_acc;

  logic                     w_first;
  logic [2:0]               w_n;
  logic [CNT_W:0]           w_span;
  logic                     w_last;
  logic signed [ACC_W-1:0]  w_sum_a;
  logic signed [ACC_W-1:0]  w_sum_b;
  logic                     w_clip_tot;

  // The first sample of a window uses the exponent it arrived with; the rest
  // of the window keeps that latched value.
  assign w_first    = (r_cnt == '0);
  assign w_n        = w_first ? r_s2_avg : r_n;
  assign w_span     = CNT_W1'(1) << w_n;
  assign w_last     = ({1'b0, r_cnt} == (w_span - CNT_W1'(1)));
  assign w_sum_a    = w_first ? ACC_W'(r_s2_a) : (r_acc_a + ACC_W'(r_s2_a));
  assign w_sum_b    = w_first ? ACC_W'(r_s2_b) : (r_acc_b + ACC_W'(r_s2_b));
  assign w_clip_tot = r_s2_clip | (!w_first && r_clip_acc);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt           <= '0;
      r_n             <= '0;
      r_acc_a         <= '0;
      r_acc_b         <= '0;
      r_clip_acc      <= 1'b0;
      M_AXIS_tdata_o  <= '0;
      M_AXIS_tvalid_o <= 1'b0;
      clip_o          <= 1'b0;
      beat_cnt_o      <= '0;
    end else if (!r_s2_valid) begin
      // Stopped or flushing: drop any partial window, keep the last tdata.
      r_cnt           <= '0;
      r_acc_a         <= '0;
      r_acc_b         <= '0;
      r_clip_acc      <= 1'b0;
      M_AXIS_tvalid_o <= 1'b0;
      clip_o          <= 1'b0;
    end else begin
      r_n             <= w_n;
      M_AXIS_tvalid_o <= w_last;
      clip_o          <= w_last && w_clip_tot;
      if (w_last) begin
        r_cnt          <= '0;
        r_acc_a        <= '0;
        r_acc_b        <= '0;
        r_clip_acc     <= 1'b0;
        // Arithmetic shift floors; the mean of 16-bit samples fits 16 bits.
        M_AXIS_tdata_o <= AXIS_TDATA_WIDTH'({16'(w_sum_b >>> w_n), 16'(w_sum_a >>> w_n)});
        beat_cnt_o     <= beat_cnt_o + 32'd1;
      end else begin
        r_cnt          <= r_cnt + CNT_W'(1);
        r_acc_a        <= w_sum_a;
        r_acc_b        <= w_sum_b;
        r_clip_acc     <= w_clip_tot;
      end
    end
  end

endmodule
`default_nettype wire
